demux_1xn_reg: RTL
==================

Name: demux_1xn_reg

Overview:
- Parametrised, registered 1-to-N demultiplexer with a valid/ready handshake on the input and on every output channel.
- Routes each accepted input word to the channel named by in_sel. Each channel has a one-entry holding register, so a stalled consumer blocks only its own channel.
- Next-generation replacement for the fixed 1x4 single-bit demux. Used wherever a shared stream fans out to N consumers.

Parameters:
- N_CH, 4, number of output channels (2..16).
- SEL_W, 2, width of in_sel; must satisfy 2**SEL_W >= N_CH.
- DATA_W, 1, payload width in bits (1..64).

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept the word on in_data/in_sel this cycle.
- in_data  input  DATA_W  payload.
- in_sel  input  SEL_W  destination channel index.
- out_valid  output  N_CH  bit k: channel k holds a word.
- out_ready  input  N_CH  bit k: consumer k takes the word this cycle.
- out_data  output  N_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- sel_err  output  1  one-cycle pulse when an out-of-range select is consumed.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset: out_valid=0, out_data=0, sel_err=0, every channel EMPTY. Reset asserted mid-transfer discards all held words immediately, without waiting for a clock edge. The first accept is possible on the first clk edge after rst_n deasserts.
- Per-channel state machine:
  - EMPTY -> FULL on accept to channel k.
  - FULL -> EMPTY on out_ready[k] with no new accept to k.
  - FULL -> FULL on out_ready[k] plus a new accept to k. The register is replaced with the new word; no bubble.
  - FULL holds when out_ready[k]=0.
- Accept condition: in_valid & in_ready.
- in_ready (combinational, from in_sel and out_ready only):
  - in_sel < N_CH: in_ready = !out_valid[in_sel] | out_ready[in_sel].
  - in_sel >= N_CH: in_ready = 1.
  - No combinational path from in_valid to in_ready.
- Latency: an accepted word appears on out_valid/out_data of its channel on the next clk edge, i.e. 1 cycle.
- Out-of-range select (in_sel >= N_CH):
  - The word is consumed and dropped.
  - sel_err=1 for exactly the following cycle.
  - No channel state changes.
- out_data of a channel is forced to 0 while its out_valid=0. Non-selected channels never change state or data.
- Ordering: words to the same channel are delivered in acceptance order. There is no ordering guarantee across channels.
- Data is never lost or duplicated on a valid channel.
- out_ready[k] while out_valid[k]=0 is ignored.
- Throughput: one word per cycle sustained, including back-to-back words to the same channel when its consumer is ready every cycle.

Optional Feature:
- Macro DEMUX_DROP_CNT_EN.
- When defined:
  - Adds output drop_cnt (16 bits): a count of out-of-range selects consumed.
  - Saturates at 16'hFFFF; reset value 0.
  - Adds input drop_clr (1 bit): synchronous clear, which takes priority over a simultaneous increment.
- When undefined: neither port exists and there is no counter logic. sel_err is present in both builds.

Test Plan:
- Reset: hold rst_n=0 mid-stream with channel 2 FULL -> out_valid=0 and out_data=0 asynchronously. After release, in_ready=1 for all selects.
- Basic routing: N_CH=4, DATA_W=8, all out_ready=1; send sel 0,1,2,3 with data A0,B1,C2,D3 on consecutive cycles -> each appears 1 cycle later on only its channel; all other out_valid bits stay 0.
- Backpressure isolation:
  - Set out_ready[1]=0 and send 0x11 then 0x22 to channel 1 -> second word sees in_ready=0 and is held off.
  - Meanwhile 0x33 to channel 3 is accepted.
  - After out_ready[1]=1 for one cycle: 0x11 is delivered, then 0x22 one cycle later.
- Simultaneous drain and fill: channel 0 FULL with 0x5A, out_ready[0]=1, accept 0xA5 to channel 0 in the same cycle -> next cycle out_valid[0]=1 with out_data 0xA5, and 0x5A was seen exactly once.
- Out-of-range select: N_CH=3, SEL_W=2, send sel=3 with data 0xFF -> in_ready=1, sel_err pulses exactly one cycle, no out_valid change. With DEMUX_DROP_CNT_EN: drop_cnt=1; drop_clr together with another bad select -> drop_cnt=0.
- Throughput and saturation:
  - 1000 random words at sel 0..3 with random out_ready -> per-channel scoreboard shows order and payload preserved with no loss.
  - With DEMUX_DROP_CNT_EN, preload the counter near the limit via 65540 bad selects -> drop_cnt=16'hFFFF.

Source files
------------

// File: rtl/demux_1xn_reg.sv
// ============================================================================
// Module   : demux_1xn_reg
// Purpose  : Registered 1-to-N valid/ready demultiplexer with a one-entry
//            holding register per channel. Optional DEMUX_DROP_CNT_EN adds a
//            saturating out-of-range drop counter (drop_cnt / drop_clr).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_1xn_reg #(
  parameter int N_CH   = 4,
  parameter int SEL_W  = 2,
  parameter int DATA_W = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  output logic [N_CH-1:0]          out_valid,
  input  logic [N_CH-1:0]          out_ready,
  output logic [N_CH*DATA_W-1:0]   out_data,
  output logic                     sel_err
`ifdef DEMUX_DROP_CNT_EN
  ,
  input  logic                     drop_clr,
  output logic [15:0]              drop_cnt
`endif
);

  localparam int               C_NSEL = 1 << SEL_W;
  localparam logic [SEL_W:0]   C_N_CH = (SEL_W + 1)'(N_CH);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  logic              w_sel_ok;
  logic              w_accept;
  logic [C_NSEL-1:0] w_rdy_vec;
  logic              r_sel_err;

  assign w_sel_ok = ({1'b0, in_sel} < C_N_CH);
  assign in_ready = w_rdy_vec[in_sel];
  assign w_accept = in_valid & in_ready;
  assign sel_err  = r_sel_err;

  // Every select code has a ready bit; codes past N_CH always accept (and drop).
  for (genvar k = 0; k < C_NSEL; k++) begin : g_sel
    if (k < N_CH) begin : g_live
      state_t            r_state;
      logic [DATA_W-1:0] r_data;
      logic              w_acc;

      assign w_acc        = w_accept & (in_sel == SEL_W'(k));
      assign w_rdy_vec[k] = (r_state == ST_EMPTY) | out_ready[k];
      assign out_valid[k] = (r_state == ST_FULL);
      assign out_data[k*DATA_W +: DATA_W] = r_data;

      // r_data is cleared whenever the channel empties so idle data reads 0.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_state <= ST_EMPTY;
          r_data  <= '0;
        end else begin
          case (r_state)
            ST_EMPTY: begin
              if (w_acc) begin
                r_state <= ST_FULL;
                r_data  <= in_data;
              end
            end
            ST_FULL: begin
              if (w_acc) begin
                r_data <= in_data;
              end else if (out_ready[k]) begin
                r_state <= ST_EMPTY;
                r_data  <= '0;
              end
            end
            default: begin
              r_state <= ST_EMPTY;
              r_data  <= '0;
            end
          endcase
        end
      end
    end else begin : g_pad
      assign w_rdy_vec[k] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_err <= 1'b0;
    end else begin
      r_sel_err <= in_valid & ~w_sel_ok;
    end
  end

`ifdef DEMUX_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  assign drop_cnt = r_drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (drop_clr) begin
      r_drop_cnt <= '0;
    end else if (in_valid && !w_sel_ok && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire
